// File: rtl/dmem_lsu_pkg.sv
// mem_pkg: shared definitions for the data-memory load/store unit.
//   F3_*        RISC-V funct3 encodings for the supported access sizes
//   lsu_state_t request/response FSM states
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/dmem_lsu_align.sv
// lsu_align: combinational lane steering for byte/half/word accesses.
//   i_we        1 = store, 0 = load
//   i_funct3    RISC-V funct3 of the access
//   i_addr_lo   byte offset within the word
//   i_wdata     right-aligned store data
//   i_rword     raw memory word for loads
//   o_be        byte enables for stores (0 for unsupported funct3)
//   o_wdata     store data replicated onto every candidate lane
//   o_rdata     selected lane(s) shifted down and sign/zero extended
//   o_misalign  half or word access not naturally aligned
//   o_bad_f3    funct3 not supported for this direction
module lsu_align
  import mem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_bad_f3
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte     = i_rword[{i_addr_lo, 3'b000} +: 8];
    w_half     = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    o_be       = '0;
    o_wdata    = i_wdata;
    o_rdata    = '0;
    o_misalign = 1'b0;
    o_bad_f3   = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      F3_H: begin
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{w_half[15]}}, w_half};
        o_misalign = i_addr_lo[0];
      end
      F3_W: begin
        o_be       = '1;
        o_rdata    = i_rword;
        o_misalign = |i_addr_lo;
      end
      F3_BU: begin
        o_rdata  = {24'h0, w_byte};
        o_bad_f3 = i_we;
      end
      F3_HU: begin
        o_rdata    = {16'h0, w_half};
        o_misalign = i_addr_lo[0];
        o_bad_f3   = i_we;
      end
      default: o_bad_f3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: data memory with valid/ready load/store unit and LATENCY wait states.
//   clk                  clock, all state changes on posedge
//   rst                  asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr, req_wdata   request fields, sampled on accept
//   rsp_valid/rsp_ready  response handshake, response held until accepted
//   rsp_rdata            extended load data, 0 for stores and faults
//   rsp_err              access faulted (range, alignment, funct3); no write done
module dmem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  lsu_state_t  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_commit;
  logic        w_a_we;
  logic [2:0]  w_a_f3;
  logic [31:0] w_a_addr;
  logic [31:0] w_a_wdata;
  logic [31:0] w_off;
  logic [AW-1:0] w_idx;
  logic        w_oor;
  logic [31:0] w_rword;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_ext;
  logic        w_misalign;
  logic        w_bad_f3;
  logic        w_err;

  assign w_accept = req_valid && (r_state == IDLE);

  // Access commits on the edge entering RESP. With LATENCY==1 that is the
  // accept edge itself, so the live request is used instead of the latches.
  always_comb begin
    w_commit = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
               ((r_state == WAIT) && (r_cnt == 4'd1));
    if (r_state == IDLE) begin
      w_a_we    = req_we;
      w_a_f3    = req_funct3;
      w_a_addr  = req_addr;
      w_a_wdata = req_wdata;
    end else begin
      w_a_we    = r_we;
      w_a_f3    = r_f3;
      w_a_addr  = r_addr;
      w_a_wdata = r_wdata;
    end
    // Wrapping subtraction makes addresses below the base look huge.
    w_off   = w_a_addr - BASE_ADDR;
    w_oor   = ({1'b0, w_off} >= LIMIT);
    w_idx   = w_off[AW+1:2];
    w_rword = r_mem[w_idx];
    w_err   = w_oor || w_misalign || w_bad_f3;
  end

  lsu_align u_align (
    .i_we       (w_a_we),
    .i_funct3   (w_a_f3),
    .i_addr_lo  (w_a_addr[1:0]),
    .i_wdata    (w_a_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata_sh),
    .o_rdata    (w_ext),
    .o_misalign (w_misalign),
    .o_bad_f3   (w_bad_f3)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_a_we && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_a_we) ? '0 : w_ext;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: self-checking bench for dmem_lsu. Instance 0 uses LATENCY=1 and
// 1024 words, instance 1 uses LATENCY=4 and 64 words. A byte-level reference
// model of the memory computes every expected response.
module tb_dmem_lsu;

  localparam logic [31:0] BASE = 32'h10010000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] mm [int];

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_lsu #(.DEPTH_WORDS(64), .BASE_ADDR(BASE), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  function automatic int unsigned depth_of(input int d);
    return (d == 0) ? 1024 : 64;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference model: sizes in bytes, memory as a map of words.
  function automatic void model(input int d, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic e);
    int unsigned size, lo;
    logic [31:0] off, word, val;
    int key;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    e   = (size == 0) || (we && f3[2]);
    off = a - BASE;
    if (off >= depth_of(d) * 4) e = 1'b1;
    if (size != 0 && (a % size) != 0) e = 1'b1;
    rd = '0;
    if (e) return;
    key  = d * 4096 + int'(off / 4);
    word = mm.exists(key) ? mm[key] : 32'h0;
    lo   = a % 4;
    if (we) begin
      for (int unsigned k = 0; k < size; k++) word[8*(lo+k) +: 8] = wd[8*k +: 8];
      mm[key] = word;
    end else begin
      val = word >> (8 * lo);
      if (size < 4) begin
        val = val & ((32'h1 << (8 * size)) - 32'h1);
        if (!f3[2] && val[8*size-1]) val = val - (32'h1 << (8 * size));
      end
      rd = val;
    end
  endfunction

  // One full transaction; lat counts clock edges from accept to rsp_valid.
  task automatic op(input int d, input logic we, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] rd, output logic e, output int lat);
    int n;
    req_we[d] = we; req_funct3[d] = f3; req_addr[d] = a; req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[d]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: req_ready stayed 0 for %0d cycles", d, n);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 50) begin @(negedge clk); lat++; end
    rd = rsp_rdata[d];
    e  = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 ||
          rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: ready=%b valid=%b rdata=%h err=%b, need 1 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; logic e, ee; int lat;
    model(0, 1'b1, 3'b010, BASE, 32'hDEADBEEF, erd, ee);
    op(0, 1'b1, 3'b010, BASE, 32'hDEADBEEF, rd, e, lat);
    checks++;
    if (lat !== 1 || e !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw dut0: lat=%0d err=%b rdata=%h, need 1 0 0", lat, e, rd);
    end
    model(0, 1'b0, 3'b010, BASE, 32'h0, erd, ee);
    op(0, 1'b0, 3'b010, BASE, 32'h0, rd, e, lat);
    checks++;
    if (lat !== 1 || e !== 1'b0 || rd !== 32'hDEADBEEF || rd !== erd) begin
      errors++;
      $display("FAIL lw dut0: lat=%0d err=%b rdata=%h, need 1 0 deadbeef", lat, e, rd);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd, erd; logic e, ee; int lat;
    model(0, 1'b1, 3'b010, BASE, 32'h11223344, erd, ee);
    op(0, 1'b1, 3'b010, BASE, 32'h11223344, rd, e, lat);
    model(0, 1'b1, 3'b000, BASE + 3, 32'h00000080, erd, ee);
    op(0, 1'b1, 3'b000, BASE + 3, 32'h00000080, rd, e, lat);
    op(0, 1'b0, 3'b010, BASE, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h80223344 || e !== 1'b0) begin
      errors++;
      $display("FAIL sb_word: rdata=%h err=%b, need 80223344 0", rd, e);
    end
    op(0, 1'b0, 3'b000, BASE + 3, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hFFFFFF80 || e !== 1'b0) begin
      errors++;
      $display("FAIL lb: rdata=%h err=%b, need ffffff80 0", rd, e);
    end
    op(0, 1'b0, 3'b100, BASE + 3, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h00000080 || e !== 1'b0) begin
      errors++;
      $display("FAIL lbu: rdata=%h err=%b, need 00000080 0", rd, e);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic e, ee; int lat;
    logic [31:0] last;
    last = BASE + 32'd4092;
    model(0, 1'b1, 3'b010, last, 32'h0BADF00D, erd, ee);
    op(0, 1'b1, 3'b010, last, 32'h0BADF00D, rd, e, lat);
    op(0, 1'b0, 3'b001, BASE + 1, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL lh_misalign: err=%b rdata=%h, need 1 0", e, rd);
    end
    op(0, 1'b1, 3'b010, 32'h1000FFFC, 32'hFFFFFFFF, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_below_base: err=%b rdata=%h, need 1 0", e, rd);
    end
    op(0, 1'b1, 3'b010, BASE + 32'd4096, 32'hFFFFFFFF, rd, e, lat);
    op(0, 1'b0, 3'b010, BASE + 32'd4096, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL lw_past_end: err=%b rdata=%h, need 1 0", e, rd);
    end
    op(0, 1'b0, 3'b010, BASE, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h80223344 || e !== 1'b0) begin
      errors++;
      $display("FAIL first_word_kept: rdata=%h err=%b, need 80223344 0", rd, e);
    end
    op(0, 1'b0, 3'b010, last, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h0BADF00D || e !== 1'b0) begin
      errors++;
      $display("FAIL last_word_kept: rdata=%h err=%b, need 0badf00d 0", rd, e);
    end
  endtask

  task automatic test_bad_funct3();
    logic [31:0] rd; logic e; int lat;
    op(0, 1'b0, 3'b011, BASE, 32'h0, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL load_f3_011: err=%b rdata=%h, need 1 0", e, rd);
    end
    op(0, 1'b1, 3'b100, BASE, 32'h55555555, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL store_f3_100: err=%b rdata=%h, need 1 0", e, rd);
    end
    op(0, 1'b0, 3'b010, BASE, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h80223344) begin
      errors++;
      $display("FAIL bad_f3_no_write: rdata=%h, need 80223344", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd, held; logic e, ee; int lat; int n;
    model(1, 1'b1, 3'b010, BASE + 16, 32'hCAFEF00D, erd, ee);
    op(1, 1'b1, 3'b010, BASE + 16, 32'hCAFEF00D, rd, e, lat);
    checks++;
    if (lat !== 4 || e !== 1'b0) begin
      errors++;
      $display("FAIL sw_lat4: lat=%0d err=%b, need 4 0", lat, e);
    end
    req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = BASE + 16;
    req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Next request waits behind this one with different fields.
    req_funct3[1] = 3'b100; req_addr[1] = BASE + 19;
    lat = 1;
    checks++;
    if (req_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_wait: req_ready=%b, need 0", req_ready[1]);
    end
    while (!rsp_valid[1] && lat < 50) begin @(negedge clk); lat++; end
    held = rsp_rdata[1];
    checks++;
    if (lat !== 4 || held !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL lw_lat4: lat=%0d rdata=%h, need 4 cafef00d", lat, held);
    end
    for (n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== held || req_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: valid=%b rdata=%h ready=%b, need 1 %h 0",
                 n, rsp_valid[1], rsp_rdata[1], req_ready[1], held);
      end
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    checks++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake: ready=%b valid=%b, need 1 0", req_ready[1], rsp_valid[1]);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    lat = 1;
    while (!rsp_valid[1] && lat < 50) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 4 || rsp_rdata[1] !== 32'h000000CA || rsp_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL second_req: lat=%0d rdata=%h err=%b, need 4 000000ca 0",
               lat, rsp_rdata[1], rsp_err[1]);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic e, ee; int lat;
    model(1, 1'b1, 3'b010, BASE + 8, 32'hAAAAAAAA, erd, ee);
    op(1, 1'b1, 3'b010, BASE + 8, 32'hAAAAAAAA, rd, e, lat);
    op(1, 1'b0, 3'b010, BASE + 8, 32'h0, rd, e, lat);
    req_we[1] = 1'b1; req_funct3[1] = 3'b010; req_addr[1] = BASE + 8;
    req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 ||
        rsp_rdata[1] !== 32'h0 || rsp_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b valid=%b rdata=%h err=%b, need 1 0 0 0",
               req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    op(1, 1'b0, 3'b010, BASE + 8, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hAAAAAAAA || e !== 1'b0) begin
      errors++;
      $display("FAIL dropped_store: rdata=%h err=%b, need aaaaaaaa 0", rd, e);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd; logic e, ee, we; logic [2:0] f3; int lat;
    int unsigned r;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        wd = $urandom;
        model(d, 1'b1, 3'b010, BASE + 32'(4 * w), wd, erd, ee);
        op(d, 1'b1, 3'b010, BASE + 32'(4 * w), wd, rd, e, lat);
      end
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0) a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
        else if (r == 1) a = BASE + 32'(depth_of(d) * 4) + 32'($urandom_range(0, 7));
        else a = BASE + 32'($urandom_range(0, 63));
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        wd = $urandom;
        model(d, we, f3, a, wd, erd, ee);
        op(d, we, f3, a, wd, rd, e, lat);
        checks++;
        if (rd !== erd || e !== ee || lat !== lat_of(d)) begin
          errors++;
          $display("FAIL rand dut%0d we=%b f3=%0d a=%h: rdata=%h err=%b lat=%0d, need %h %b %0d",
                   d, we, f3, a, rd, e, lat, erd, ee, lat_of(d));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = '0;
      req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_store_load();
    test_byte();
    test_errors();
    test_bad_funct3();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
